// File: rtl/beep_sequencer.sv
// Buzzer pattern generator behind the parking FSM: a single chirp when the gate opens,
// and a FULL_BEEPS burst when a car requests entry into a full lot.
module beep_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int CHIRP_MS   = 100,
    parameter int GAP_MS     = 100,
    parameter int FULL_BEEPS = 3,
    parameter int TONE_DIV   = 12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_open,
    input  logic       full,
    input  logic       entry_req,
    input  logic       enable,
    output logic       beep,
    output logic       busy,
    output logic [1:0] pattern
);

    localparam int MS_MAX = (CHIRP_MS > GAP_MS) ? CHIRP_MS : GAP_MS;
    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int BC_W   = $clog2(FULL_BEEPS + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]   ON_LAST    = MS_W'(CHIRP_MS - 1);
    localparam logic [MS_W-1:0]   GAP_LAST   = MS_W'(GAP_MS - 1);
    localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(TONE_DIV - 1);
    localparam logic [BC_W-1:0]   TOTAL_REJ  = BC_W'(FULL_BEEPS);
    localparam logic [BC_W-1:0]   TOTAL_CHRP = BC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;
    typedef enum logic [1:0] {PAT_IDLE = 2'b00, PAT_CHIRP = 2'b01, PAT_REJ = 2'b10} pat_t;

    state_t             state_q, state_d;
    pat_t               pattern_q, start_pat;
    logic               door_q, req_q, tone_q;
    logic [PRE_W-1:0]   ms_pre;
    logic [MS_W-1:0]    ms_cnt;
    logic [TONE_W-1:0]  tone_cnt;
    logic [BC_W-1:0]    beep_cnt;

    logic door_rise, req_rise, reject, start, tick, phase_end, last_beep;
    logic [MS_W-1:0] phase_last;

    always_comb begin
        door_rise  = door_open & ~door_q;
        req_rise   = entry_req & ~req_q;
        reject     = req_rise & full;
        tick       = (ms_pre == PRE_LAST);
        phase_last = (state_q == S_ON) ? ON_LAST : GAP_LAST;
        phase_end  = tick && (ms_cnt == phase_last) && (state_q != S_IDLE);
        last_beep  = (beep_cnt == ((pattern_q == PAT_REJ) ? TOTAL_REJ : TOTAL_CHRP));
        start      = 1'b0;
        start_pat  = PAT_IDLE;
        state_d    = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (reject) begin
                    start = 1'b1; start_pat = PAT_REJ;
                end else if (door_rise) begin
                    start = 1'b1; start_pat = PAT_CHIRP;
                end
            end
            S_ON: begin
                // Only a reject may pre-empt a chirp; a running reject is never interrupted.
                if (pattern_q == PAT_CHIRP && reject) begin
                    start = 1'b1; start_pat = PAT_REJ;
                end else if (phase_end) begin
                    state_d = last_beep ? S_IDLE : S_OFF;
                end
            end
            S_OFF: begin
                if (pattern_q == PAT_CHIRP && reject) begin
                    start = 1'b1; start_pat = PAT_REJ;
                end else if (phase_end) begin
                    state_d = S_ON;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) state_d = S_ON;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pattern_q <= PAT_IDLE;
            door_q    <= door_open;
            req_q     <= entry_req;
            tone_q    <= 1'b0;
            ms_pre    <= '0;
            ms_cnt    <= '0;
            tone_cnt  <= '0;
            beep_cnt  <= '0;
        end else begin
            door_q  <= door_open;
            req_q   <= entry_req;
            state_q <= state_d;
            if (start) begin
                pattern_q <= start_pat;
                beep_cnt  <= TOTAL_CHRP;
                ms_pre    <= '0;
                ms_cnt    <= '0;
                tone_cnt  <= '0;
                tone_q    <= 1'b1;
            end else if (state_q != S_IDLE) begin
                if (phase_end) begin
                    ms_pre   <= '0;
                    ms_cnt   <= '0;
                    tone_cnt <= '0;
                    if (state_q == S_ON) begin
                        tone_q <= 1'b0;
                        if (last_beep) begin
                            pattern_q <= PAT_IDLE;
                            beep_cnt  <= '0;
                        end
                    end else begin
                        tone_q   <= 1'b1;
                        beep_cnt <= beep_cnt + BC_W'(1);
                    end
                end else begin
                    ms_pre <= tick ? '0 : ms_pre + PRE_W'(1);
                    if (tick) ms_cnt <= ms_cnt + MS_W'(1);
                    if (state_q == S_ON) begin
                        if (tone_cnt == TONE_LAST) begin
                            tone_cnt <= '0;
                            tone_q   <= ~tone_q;
                        end else begin
                            tone_cnt <= tone_cnt + TONE_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign beep    = tone_q & enable;
    assign busy    = (state_q != S_IDLE);
    assign pattern = pattern_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer with a shrunken timebase (4-cycle ms, 2-cycle tone).
module tb_beep_sequencer;

    localparam int TICK_DIV = 4, CHIRP_MS = 3, GAP_MS = 2, FULL_BEEPS = 3, TONE_DIV = 2;
    localparam int ON_CYC  = CHIRP_MS * TICK_DIV;
    localparam int OFF_CYC = GAP_MS * TICK_DIV;

    logic clk = 1'b0, reset = 1'b1;
    logic door_open = 1'b0, full = 1'b0, entry_req = 1'b0, enable = 1'b1;
    logic beep, busy;
    logic [1:0] pattern;
    int errors = 0, checks = 0;

    beep_sequencer #(
        .TICK_DIV(TICK_DIV), .CHIRP_MS(CHIRP_MS), .GAP_MS(GAP_MS),
        .FULL_BEEPS(FULL_BEEPS), .TONE_DIV(TONE_DIV)
    ) dut (
        .clk(clk), .reset(reset), .door_open(door_open), .full(full),
        .entry_req(entry_req), .enable(enable), .beep(beep), .busy(busy), .pattern(pattern)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {busy, pattern, beep} k cycles after the triggering cycle.
    function automatic logic [3:0] exp_vec(input int k, input int beeps, input logic [1:0] pat,
                                           input logic en);
        int idx, pos;
        logic b, t;
        idx = k - 1;
        pos = idx % (ON_CYC + OFF_CYC);
        b   = (k >= 1) && (idx < beeps * (ON_CYC + OFF_CYC) - OFF_CYC);
        t   = b && (pos < ON_CYC) && ((pos % (2 * TONE_DIV)) < TONE_DIV) && en;
        return {b, b ? pat : 2'b00, t};
    endfunction

    task automatic settle();
        door_open = 0; full = 0; entry_req = 0; enable = 1;
        repeat (70) step();
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) step();
        if ({busy, pattern, beep} !== 4'b0000) begin
            errors++; $display("FAIL reset_hold got=%b want=0000", {busy, pattern, beep});
        end
        checks++;
        reset = 0;
        step();
        if ({busy, pattern, beep} !== 4'b0000) begin
            errors++; $display("FAIL reset_release got=%b want=0000", {busy, pattern, beep});
        end
        checks++;
    endtask

    task automatic test_chirp();
        door_open = 1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if ({busy, pattern, beep} !== exp_vec(k, 1, 2'b01, 1'b1)) begin
                errors++;
                $display("FAIL chirp k=%0d got=%b want=%b", k, {busy, pattern, beep}, exp_vec(k, 1, 2'b01, 1'b1));
            end
            checks++;
        end
        settle();
    endtask

    task automatic test_reject_burst();
        full = 1; entry_req = 1;
        for (int k = 1; k <= 56; k++) begin
            step();
            if ({busy, pattern, beep} !== exp_vec(k, 3, 2'b10, 1'b1)) begin
                errors++;
                $display("FAIL reject k=%0d got=%b want=%b", k, {busy, pattern, beep}, exp_vec(k, 3, 2'b10, 1'b1));
            end
            checks++;
        end
        settle();
    endtask

    task automatic test_abort_chirp();
        door_open = 1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if ({busy, pattern, beep} !== exp_vec(k, 1, 2'b01, 1'b1)) begin
                errors++;
                $display("FAIL abort_pre k=%0d got=%b want=%b", k, {busy, pattern, beep}, exp_vec(k, 1, 2'b01, 1'b1));
            end
            checks++;
        end
        full = 1; entry_req = 1;
        for (int k = 1; k <= 55; k++) begin
            step();
            if ({busy, pattern, beep} !== exp_vec(k, 3, 2'b10, 1'b1)) begin
                errors++;
                $display("FAIL abort_rej k=%0d got=%b want=%b", k, {busy, pattern, beep}, exp_vec(k, 3, 2'b10, 1'b1));
            end
            checks++;
        end
        settle();
    endtask

    task automatic test_door_in_burst();
        full = 1; entry_req = 1;
        for (int k = 1; k <= 56; k++) begin
            step();
            if (k == 15) door_open = 1;
            if ({busy, pattern, beep} !== exp_vec(k, 3, 2'b10, 1'b1)) begin
                errors++;
                $display("FAIL door_in_burst k=%0d got=%b want=%b", k, {busy, pattern, beep}, exp_vec(k, 3, 2'b10, 1'b1));
            end
            checks++;
        end
        settle();
    endtask

    task automatic test_enable_and_ignore();
        enable = 0; full = 1; entry_req = 1;
        for (int k = 1; k <= 56; k++) begin
            step();
            if ({busy, pattern, beep} !== exp_vec(k, 3, 2'b10, 1'b0)) begin
                errors++;
                $display("FAIL mute k=%0d got=%b want=%b", k, {busy, pattern, beep}, exp_vec(k, 3, 2'b10, 1'b0));
            end
            checks++;
        end
        enable = 1; full = 0; entry_req = 0;
        step();
        entry_req = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if ({busy, pattern, beep} !== 4'b0000) begin
                errors++; $display("FAIL not_full k=%0d got=%b want=0000", k, {busy, pattern, beep});
            end
            checks++;
        end
        settle();
    endtask

    task automatic test_same_cycle();
        full = 1; entry_req = 1; door_open = 1;
        step();
        if ({busy, pattern, beep} !== 4'b1101) begin
            errors++; $display("FAIL same_cycle got=%b want=1101", {busy, pattern, beep});
        end
        checks++;
        settle();
    endtask

    task automatic test_reset_mid();
        full = 1; entry_req = 1;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 22) door_open = 1;
            if ({busy, pattern, beep} !== exp_vec(k, 3, 2'b10, 1'b1)) begin
                errors++;
                $display("FAIL pre_reset k=%0d got=%b want=%b", k, {busy, pattern, beep}, exp_vec(k, 3, 2'b10, 1'b1));
            end
            checks++;
        end
        reset = 1;
        step();
        if ({busy, pattern, beep} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset got=%b want=0000", {busy, pattern, beep});
        end
        checks++;
        reset = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if ({busy, pattern, beep} !== 4'b0000) begin
                errors++; $display("FAIL post_reset k=%0d got=%b want=0000", k, {busy, pattern, beep});
            end
            checks++;
        end
        door_open = 0;
        step();
        door_open = 1;
        step();
        if ({busy, pattern, beep} !== 4'b1011) begin
            errors++; $display("FAIL rechirp got=%b want=1011", {busy, pattern, beep});
        end
        checks++;
        settle();
    endtask

    initial begin
        test_reset();
        test_chirp();
        test_reject_burst();
        test_abort_chirp();
        test_door_in_burst();
        test_enable_and_ignore();
        test_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
